// File: rtl/atm_account_server.sv
// Bank-side account server: authenticates ATM requests against a 4-entry account
// table and executes balance/PIN operations atomically, replying over valid/ready.
module atm_account_server #(
    parameter int unsigned         AMT_W     = 6,
    parameter int unsigned         BAL_W     = 8,
    parameter logic [15:0]         ACC_IDS   = 16'h0123,
    parameter logic [15:0]         PINS_INIT = 16'h3210,
    parameter logic [4*BAL_W-1:0]  BAL_INIT  = 32'h32050028,
    parameter int unsigned         MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [3:0]       req_acc,
    input  logic [3:0]       req_pin,
    input  logic [3:0]       req_dest,
    input  logic [AMT_W-1:0] req_amount,
    input  logic [3:0]       req_newpin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [BAL_W-1:0] rsp_balance,
    output logic [3:0]       lock_status
);
    localparam int unsigned NUM_ACC = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SUM_W   = BAL_W + 1;
    localparam int unsigned CNT_W   = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] OP_AUTH = 3'd0, OP_WITHDRAW = 3'd1, OP_DEPOSIT = 3'd2,
                           OP_TRANSFER = 3'd3, OP_CHANGE_PIN = 3'd4, OP_BALANCE = 3'd5;
    localparam logic [2:0] ST_OK = 3'd0, ST_NO_ACCOUNT = 3'd1, ST_LOCKED = 3'd2,
                           ST_BAD_PIN = 3'd3, ST_BAD_OP = 3'd4, ST_INSUFFICIENT = 3'd5,
                           ST_OVERFLOW = 3'd6, ST_BAD_DEST = 3'd7;

    typedef enum logic [1:0] {IDLE, LOOKUP, EXEC, RESP} state_e;

    typedef struct packed {
        logic [2:0]       op;
        logic [3:0]       acc;
        logic [3:0]       pin;
        logic [3:0]       dest;
        logic [AMT_W-1:0] amount;
        logic [3:0]       newpin;
    } req_t;

    state_e             state_q, state_d;
    req_t               req_q;
    logic [IDX_W-1:0]   src_idx_q, dst_idx_q, lk_src_idx, lk_dst_idx;
    logic               src_found_q, dst_found_q, lk_src_found, lk_dst_found;
    logic [3:0]         pin_q  [NUM_ACC];
    logic [BAL_W-1:0]   bal_q  [NUM_ACC];
    logic [CNT_W-1:0]   fail_q [NUM_ACC];

    logic [2:0]         ex_status;
    logic [BAL_W-1:0]   src_bal, dst_bal, src_new, dst_new, ex_rsp_bal;
    logic [SUM_W-1:0]   src_sum, dst_sum;
    logic [CNT_W-1:0]   fail_inc;
    logic               src_short, amt_zero;
    logic               ex_wr_src, ex_wr_dst, ex_wr_pin, ex_clr_fail, ex_inc_fail, ex_set_lock;

    // ID -> table index resolution for source and destination
    always_comb begin
        lk_src_idx   = '0;
        lk_dst_idx   = '0;
        lk_src_found = 1'b0;
        lk_dst_found = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (ACC_IDS[4*i +: 4] == req_q.acc) begin
                lk_src_idx   = IDX_W'(i);
                lk_src_found = 1'b1;
            end
            if (ACC_IDS[4*i +: 4] == req_q.dest) begin
                lk_dst_idx   = IDX_W'(i);
                lk_dst_found = 1'b1;
            end
        end
    end

    // Next state plus the prioritized EXEC checks; results commit only in EXEC
    always_comb begin
        state_d     = state_q;
        ex_status   = ST_OK;
        ex_wr_src   = 1'b0;
        ex_wr_dst   = 1'b0;
        ex_wr_pin   = 1'b0;
        ex_clr_fail = 1'b0;
        ex_inc_fail = 1'b0;
        ex_set_lock = 1'b0;
        src_bal     = bal_q[src_idx_q];
        dst_bal     = bal_q[dst_idx_q];
        src_new     = src_bal;
        dst_new     = dst_bal;
        fail_inc    = fail_q[src_idx_q] + CNT_W'(1);
        src_sum     = SUM_W'(src_bal) + SUM_W'(req_q.amount);
        dst_sum     = SUM_W'(dst_bal) + SUM_W'(req_q.amount);
        src_short   = SUM_W'(req_q.amount) > SUM_W'(src_bal);
        amt_zero    = (req_q.amount == '0);

        unique case (state_q)
            IDLE:    if (req_valid && req_ready) state_d = LOOKUP;
            LOOKUP:  state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (!src_found_q) begin
            ex_status = ST_NO_ACCOUNT;
        end else if (lock_status[src_idx_q]) begin
            ex_status = ST_LOCKED;
        end else if (req_q.pin != pin_q[src_idx_q]) begin
            ex_status   = ST_BAD_PIN;
            ex_inc_fail = 1'b1;
            ex_set_lock = (fail_inc == CNT_W'(MAX_TRIES));
        end else begin
            ex_clr_fail = 1'b1;
            case (req_q.op)
                OP_AUTH, OP_BALANCE: ex_status = ST_OK;
                OP_WITHDRAW: begin
                    if (amt_zero)       ex_status = ST_BAD_OP;
                    else if (src_short) ex_status = ST_INSUFFICIENT;
                    else begin
                        src_new   = src_bal - BAL_W'(req_q.amount);
                        ex_wr_src = 1'b1;
                    end
                end
                OP_DEPOSIT: begin
                    if (amt_zero)             ex_status = ST_BAD_OP;
                    else if (src_sum[BAL_W])  ex_status = ST_OVERFLOW;
                    else begin
                        src_new   = src_sum[BAL_W-1:0];
                        ex_wr_src = 1'b1;
                    end
                end
                OP_TRANSFER: begin
                    if (!dst_found_q || dst_idx_q == src_idx_q) ex_status = ST_BAD_DEST;
                    else if (amt_zero)                           ex_status = ST_BAD_OP;
                    else if (src_short)                          ex_status = ST_INSUFFICIENT;
                    else if (dst_sum[BAL_W])                     ex_status = ST_OVERFLOW;
                    else begin
                        src_new   = src_bal - BAL_W'(req_q.amount);
                        dst_new   = dst_sum[BAL_W-1:0];
                        ex_wr_src = 1'b1;
                        ex_wr_dst = 1'b1;
                    end
                end
                OP_CHANGE_PIN: ex_wr_pin = 1'b1;
                default:       ex_status = ST_BAD_OP;
            endcase
        end

        ex_rsp_bal = src_found_q ? src_new : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_status  <= '0;
            rsp_balance <= '0;
            lock_status <= '0;
            req_q       <= '0;
            src_idx_q   <= '0;
            dst_idx_q   <= '0;
            src_found_q <= 1'b0;
            dst_found_q <= 1'b0;
            for (int i = 0; i < NUM_ACC; i++) begin
                pin_q[i]  <= PINS_INIT[4*i +: 4];
                bal_q[i]  <= BAL_INIT[BAL_W*i +: BAL_W];
                fail_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            req_ready <= (state_d == IDLE);
            rsp_valid <= (state_d == RESP);
            if (state_q == IDLE && req_valid && req_ready) begin
                req_q.op     <= req_op;
                req_q.acc    <= req_acc;
                req_q.pin    <= req_pin;
                req_q.dest   <= req_dest;
                req_q.amount <= req_amount;
                req_q.newpin <= req_newpin;
            end
            if (state_q == LOOKUP) begin
                src_idx_q   <= lk_src_idx;
                dst_idx_q   <= lk_dst_idx;
                src_found_q <= lk_src_found;
                dst_found_q <= lk_dst_found;
            end
            if (state_q == EXEC) begin
                rsp_status  <= ex_status;
                rsp_balance <= ex_rsp_bal;
                if (ex_wr_src)   bal_q[src_idx_q]       <= src_new;
                if (ex_wr_dst)   bal_q[dst_idx_q]       <= dst_new;
                if (ex_wr_pin)   pin_q[src_idx_q]       <= req_q.newpin;
                if (ex_clr_fail) fail_q[src_idx_q]      <= '0;
                if (ex_inc_fail) fail_q[src_idx_q]      <= fail_inc;
                if (ex_set_lock) lock_status[src_idx_q] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_atm_account_server.sv
// Bench for atm_account_server: directed scenarios plus randomized transactions
// checked against an account-table reference model.
module tb_atm_account_server;
    localparam int AMT_W = 6;
    localparam int BAL_W = 8;
    localparam int MAX_TRIES = 3;
    localparam int BAL_MAX = (1 << BAL_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = '0;
    logic [3:0]       req_acc = '0;
    logic [3:0]       req_pin = '0;
    logic [3:0]       req_dest = '0;
    logic [AMT_W-1:0] req_amount = '0;
    logic [3:0]       req_newpin = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [2:0]       rsp_status;
    logic [BAL_W-1:0] rsp_balance;
    logic [3:0]       lock_status;

    atm_account_server #(.AMT_W(AMT_W), .BAL_W(BAL_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_acc(req_acc), .req_pin(req_pin),
        .req_dest(req_dest), .req_amount(req_amount), .req_newpin(req_newpin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_balance(rsp_balance),
        .lock_status(lock_status)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Account table model, indexed by table slot
    int m_id  [4] = '{3, 2, 1, 0};
    int m_pin [4];
    int m_bal [4];
    int m_fail[4];
    int m_lock[4];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pin = '{0, 1, 2, 3};
        m_bal = '{40, 0, 5, 50};
        m_fail = '{0, 0, 0, 0};
        m_lock = '{0, 0, 0, 0};
    endtask

    function automatic int model_locks();
        int v = 0;
        for (int i = 0; i < 4; i++) if (m_lock[i] != 0) v |= (1 << i);
        return v;
    endfunction

    function automatic int find_acc(input int id);
        for (int i = 0; i < 4; i++) if (m_id[i] == id) return i;
        return -1;
    endfunction

    task automatic model_txn(input int op, input int acc, input int pin, input int dest,
                             input int amt, input int newpin, output int st, output int bal);
        int s, d;
        s = find_acc(acc);
        d = find_acc(dest);
        if (s < 0) begin st = 1; bal = 0; return; end
        bal = m_bal[s];
        if (m_lock[s] != 0) begin st = 2; return; end
        if (pin != m_pin[s]) begin
            m_fail[s]++;
            if (m_fail[s] >= MAX_TRIES) m_lock[s] = 1;
            st = 3;
            return;
        end
        m_fail[s] = 0;
        st = 0;
        case (op)
            0, 5: st = 0;
            1: if (amt == 0) st = 4; else if (amt > m_bal[s]) st = 5; else m_bal[s] -= amt;
            2: if (amt == 0) st = 4; else if (m_bal[s] + amt > BAL_MAX) st = 6; else m_bal[s] += amt;
            3: begin
                if (d < 0 || d == s)             st = 7;
                else if (amt == 0)               st = 4;
                else if (amt > m_bal[s])         st = 5;
                else if (m_bal[d] + amt > BAL_MAX) st = 6;
                else begin
                    m_bal[s] -= amt;
                    m_bal[d] += amt;
                end
            end
            4: m_pin[s] = newpin;
            default: st = 4;
        endcase
        bal = m_bal[s];
    endtask

    // One request/response exchange; exp_st/exp_bal < 0 means take the model's answer
    task automatic do_txn(input int op, input int acc, input int pin, input int dest,
                          input int amt, input int newpin, input int hold, input int pulse,
                          input int exp_st, input int exp_bal);
        int mst, mbal, est, ebal, cyc;
        model_txn(op, acc, pin, dest, amt, newpin, mst, mbal);
        est  = (exp_st  < 0) ? mst  : exp_st;
        ebal = (exp_bal < 0) ? mbal : exp_bal;
        @(negedge clk);
        cyc = 0;
        while (!req_ready && cyc < 10) begin @(negedge clk); cyc++; end
        check("req_ready_idle", int'(req_ready), 1);
        req_op = 3'(op); req_acc = 4'(acc); req_pin = 4'(pin); req_dest = 4'(dest);
        req_amount = AMT_W'(amt); req_newpin = 4'(newpin);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_busy", int'(req_ready), 0);
        cyc = 1;
        while (!rsp_valid && cyc < 10) begin @(posedge clk); cyc++; @(negedge clk); end
        check("latency", cyc, 3);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", int'(rsp_valid), 1);
            check("hold_status", int'(rsp_status), est);
            check("hold_balance", int'(rsp_balance), ebal);
            check("hold_req_ready", int'(req_ready), 0);
            req_valid = (pulse != 0 && h == 1);
            req_op = 3'd2; req_acc = 4'd0; req_pin = 4'd3; req_amount = AMT_W'(7);
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        check("rsp_valid", int'(rsp_valid), 1);
        check("rsp_status", int'(rsp_status), est);
        check("rsp_balance", int'(rsp_balance), ebal);
        check("lock_status", int'(lock_status), model_locks());
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", int'(rsp_valid), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, pin, op, dest, amt, s;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_status", int'(rsp_status), 0);
        check("rst_rsp_balance", int'(rsp_balance), 0);
        check("rst_lock_status", int'(lock_status), 0);
        rst = 1'b0;

        // Withdraw path including exact-balance and insufficient funds
        do_txn(0, 3, 0, 0, 0, 0, 0, 0, 0, 40);
        do_txn(1, 3, 0, 0, 40, 0, 0, 0, 0, 0);
        do_txn(1, 3, 0, 0, 1, 0, 0, 0, 5, 0);
        // Deposits up to overflow
        do_txn(2, 0, 3, 0, 63, 0, 0, 0, 0, 113);
        do_txn(2, 0, 3, 0, 63, 0, 0, 0, 0, 176);
        do_txn(2, 0, 3, 0, 63, 0, 0, 0, 0, 239);
        do_txn(2, 0, 3, 0, 63, 0, 0, 0, 6, 239);
        // Transfers
        do_txn(3, 1, 2, 3, 5, 0, 0, 0, 0, 0);
        do_txn(5, 3, 0, 0, 0, 0, 0, 0, 0, 5);
        do_txn(3, 1, 2, 1, 1, 0, 0, 0, 7, 0);
        do_txn(3, 1, 2, 9, 1, 0, 0, 0, 7, 0);
        // Lockout after repeated bad PINs
        do_txn(1, 2, 7, 0, 1, 0, 0, 0, 3, 0);
        do_txn(1, 2, 7, 0, 1, 0, 0, 0, 3, 0);
        do_txn(1, 2, 7, 0, 1, 0, 0, 0, 3, 0);
        check("lock_after_bad_pins", int'(lock_status), 2);
        do_txn(0, 2, 1, 0, 0, 0, 0, 0, 2, 0);
        do_reset();
        check("lock_cleared_by_rst", int'(lock_status), 0);
        do_txn(0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        // PIN change, bad op, unknown account
        do_txn(4, 3, 0, 0, 0, 9, 0, 0, 0, 40);
        do_txn(0, 3, 0, 0, 0, 0, 0, 0, 3, 40);
        do_txn(0, 3, 9, 0, 0, 0, 0, 0, 0, 40);
        do_txn(6, 3, 9, 0, 0, 0, 0, 0, 4, 40);
        do_txn(0, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        // Backpressure with an ignored request pulse
        do_txn(5, 0, 3, 0, 0, 0, 5, 1, 0, 50);

        // Reset while the request sits in EXEC drops it
        @(negedge clk);
        req_op = 3'd2; req_acc = 4'd0; req_pin = 4'd3; req_amount = AMT_W'(10);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("exec_rst_rsp_valid", int'(rsp_valid), 0);
        check("exec_rst_req_ready", int'(req_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_txn(5, 3, 0, 0, 0, 0, 0, 0, 0, 40);
        do_txn(5, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        do_txn(5, 1, 2, 0, 0, 0, 0, 0, 0, 5);
        do_txn(5, 0, 3, 0, 0, 0, 0, 0, 0, 50);

        // Randomized traffic against the model
        for (int t = 0; t < 150; t++) begin
            acc  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(0, 3));
            s    = find_acc(acc);
            pin  = (s >= 0 && $urandom_range(0, 4) != 0) ? m_pin[s] : int'($urandom_range(0, 15));
            op   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7)) : int'($urandom_range(0, 5));
            dest = int'($urandom_range(0, 5));
            amt  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            do_txn(op, acc, pin, dest, amt, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), -1, -1);
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/atm_account_server.md
Name: atm_account_server

Overview:
- Bank-side responder to the ATM controller's transaction requests.
- Holds the account table: 4 accounts, each with an ID, a PIN, a balance and a lockout state.
- Authenticates every request and executes withdraw, deposit, transfer, PIN change or balance query atomically.
- Returns a status code and the resulting balance over a valid/ready response channel.

Parameters:
- AMT_W, 6, request amount width
- BAL_W, 8, balance width
- ACC_IDS, 16'h0123, packed account IDs {acc3,acc2,acc1,acc0}; acc0=3, acc1=2, acc2=1, acc3=0
- PINS_INIT, 16'h3210, packed reset PINs; acc0=0, acc1=1, acc2=2, acc3=3
- BAL_INIT, 32'h32050028, packed reset balances; acc0=40, acc1=0, acc2=5, acc3=50
- MAX_TRIES, 3, consecutive bad PINs before lockout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  server can accept a request
- req_op  in  3  0 AUTH, 1 WITHDRAW, 2 DEPOSIT, 3 TRANSFER, 4 CHANGE_PIN, 5 BALANCE
- req_acc  in  4  source account ID
- req_pin  in  4  PIN presented
- req_dest  in  4  destination account ID (TRANSFER only)
- req_amount  in  AMT_W  amount
- req_newpin  in  4  new PIN (CHANGE_PIN only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  ATM accepts response
- rsp_status  out  3  0 OK, 1 NO_ACCOUNT, 2 LOCKED, 3 BAD_PIN, 4 BAD_OP, 5 INSUFFICIENT, 6 OVERFLOW, 7 BAD_DEST
- rsp_balance  out  BAL_W  source balance after the operation
- lock_status  out  4  per-account lockout flags

Behaviour:
- Reset (async, active-high): FSM to IDLE; req_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0, lock_status=0.
- Reset also restores PINs and balances from the parameters and clears fail counters.
- Reset during a pending request or response drops it.
- FSM states: IDLE, LOOKUP, EXEC, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register all req_* fields and go to LOOKUP. Inputs are sampled only on this accept edge.
- LOOKUP (1 cycle): resolve the source index and destination index from the IDs; set a found flag for each.
- EXEC (1 cycle): evaluate checks in priority order; the first failure sets the status and nothing is updated.
  1. Source not found: NO_ACCOUNT, rsp_balance=0.
  2. Source locked: LOCKED.
  3. PIN mismatch: BAD_PIN; increment the fail counter; when the counter reaches MAX_TRIES, set the lock flag. The response that causes the lock still reports BAD_PIN.
  4. req_op > 5: BAD_OP.
  5. Operation checks, below.
- A correct PIN on a non-locked account clears its fail counter, including when a later check fails.
- AUTH and BALANCE: OK.
- WITHDRAW:
  - amount 0: BAD_OP.
  - amount > balance: INSUFFICIENT.
  - otherwise: balance -= amount; OK. Amount equal to balance is allowed and leaves 0.
- DEPOSIT:
  - amount 0: BAD_OP.
  - balance+amount > 2^BAL_W-1: OVERFLOW. Compute the sum at BAL_W+1 bits; no wrap.
  - otherwise: add; OK.
- TRANSFER:
  - destination not found, or destination = source: BAD_DEST.
  - amount 0: BAD_OP.
  - insufficient source balance: INSUFFICIENT.
  - destination overflow: OVERFLOW.
  - otherwise: debit source and credit destination on the same edge (atomic); OK.
- CHANGE_PIN: store req_newpin; OK. The new PIN is effective for the next request.
- rsp_balance = source balance after EXEC (the updated value on OK, unchanged on failure). Go to RESP.
- RESP:
  - rsp_valid=1; rsp_status and rsp_balance held stable until rsp_valid&&rsp_ready, then go to IDLE.
  - req_ready is 0 in LOOKUP, EXEC and RESP; requests are not accepted while busy.
  - A new request cannot be accepted on the same edge as the response handshake.
- Latency: taking the accept edge as edge 1, rsp_valid asserts after edge 3. Minimum request-to-request interval is 4 cycles with rsp_ready tied high.
- Lock flags clear only on rst. lock_status is registered and reflects updates made in EXEC.

Test Plan:
- After reset, AUTH acc=3 pin=0 -> OK, rsp_balance=40, rsp_valid rises after the 3rd edge counting the accept edge. Then WITHDRAW acc=3 pin=0 amount=40 -> OK, balance 0. Then WITHDRAW amount=1 -> INSUFFICIENT, balance 0.
- DEPOSIT acc=0 pin=3 amount=63 with balance 50 -> OK, 113. Repeat three more times: 176, 239, then OVERFLOW with balance 239 unchanged.
- TRANSFER acc=1 pin=2 dest=3 amount=5 -> OK, rsp_balance=0, and acc 3 balance +5. TRANSFER dest=1 (self) -> BAD_DEST. dest=9 -> BAD_DEST.
- Three WITHDRAWs acc=2 pin=7 -> BAD_PIN x3, lock_status[1]=1. Then the correct PIN=1 -> LOCKED. After rst, PIN=1 -> OK.
- CHANGE_PIN acc=3 pin=0 newpin=9 -> OK. Then AUTH pin=0 -> BAD_PIN; AUTH pin=9 -> OK. req_op=6 with a correct PIN -> BAD_OP. req_acc=5 -> NO_ACCOUNT, rsp_balance=0.
- Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp fields remain stable, req_ready stays 0, and a req_valid pulse is ignored. Assert rst during EXEC: rsp_valid=0 and balances restored to 40/0/5/50.
